// File: rtl/vram_console_writer.sv
// Character-stream writer for the text-mode VRAM write port.
// Turns an ASCII byte stream into single-cycle VRAM word writes and tracks
// the cursor. Line advances wrap to the top and blank the entered line, so
// the block never reads VRAM back.
module vram_console_writer #(
  parameter int          COLS       = 50,
  parameter int          ROWS       = 15,
  parameter logic [7:0]  RESET_ATTR = 8'h0F
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  input  logic [7:0]  in_attr,
  output logic        in_ready,
  output logic        ram_ce,
  output logic [11:0] ram_addr,
  output logic [15:0] ram_data,
  output logic [7:0]  cur_col,
  output logic [7:0]  cur_row
);

  localparam logic [1:0] ST_CLEAR_ALL = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_WRITE     = 2'd2;
  localparam logic [1:0] ST_CLEAR_ROW = 2'd3;

  // 13 bits so a full 4096-cell screen count is representable.
  localparam logic [12:0] SCREEN_LEN = 13'(COLS * ROWS);
  localparam logic [12:0] ROW_LEN    = 13'(COLS);
  localparam logic [11:0] ROW_STEP   = 12'(COLS);
  localparam logic [7:0]  LAST_COL   = 8'(COLS - 1);
  localparam logic [7:0]  LAST_ROW   = 8'(ROWS - 1);

  logic [1:0]  state;
  logic [7:0]  col;
  logic [7:0]  row;
  logic [11:0] row_base;   // row * COLS, maintained incrementally
  logic [12:0] clr_cnt;
  logic [7:0]  attr;       // attribute used for blanking
  logic        wrap;       // pending row clear after the current char write

  logic [7:0]  row_nx;
  logic [11:0] base_nx;
  logic [12:0] clr_len;
  logic [11:0] clr_addr;
  logic        printable;

  // Next-row position, clear length/address for the active clear mode.
  always_comb begin
    row_nx    = (row == LAST_ROW) ? 8'd0  : row + 8'd1;
    base_nx   = (row == LAST_ROW) ? 12'd0 : row_base + ROW_STEP;
    clr_len   = (state == ST_CLEAR_ALL) ? SCREEN_LEN : ROW_LEN;
    clr_addr  = (state == ST_CLEAR_ALL) ? clr_cnt[11:0] : row_base + clr_cnt[11:0];
    printable = (in_char >= 8'h20) && (in_char <= 8'h7E);
  end

  assign in_ready = (state == ST_IDLE);
  assign cur_col  = col;
  assign cur_row  = row;

  // Main FSM: byte decode, cursor tracking and registered VRAM write port.
  // Every clear sequence starts issuing on its entry edge and spends one
  // trailing cycle with clr_cnt == clr_len before handing back to IDLE.
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state    <= ST_CLEAR_ALL;
      col      <= 8'd0;
      row      <= 8'd0;
      row_base <= 12'd0;
      clr_cnt  <= 13'd0;
      attr     <= RESET_ATTR;
      wrap     <= 1'b0;
      ram_ce   <= 1'b0;
      ram_addr <= 12'd0;
      ram_data <= 16'd0;
    end else begin
      ram_ce <= 1'b0;
      case (state)
        ST_CLEAR_ALL, ST_CLEAR_ROW: begin
          if (clr_cnt == clr_len) begin
            state <= ST_IDLE;
          end else begin
            ram_ce   <= 1'b1;
            ram_addr <= clr_addr;
            ram_data <= {attr, 8'h20};
            clr_cnt  <= clr_cnt + 13'd1;
          end
        end
        ST_WRITE: begin
          if (wrap) begin
            // Cursor already points at the new row; blank its first cell now.
            ram_ce   <= 1'b1;
            ram_addr <= row_base;
            ram_data <= {attr, 8'h20};
            clr_cnt  <= 13'd1;
            state    <= ST_CLEAR_ROW;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          if (in_valid) begin
            if (printable) begin
              ram_ce   <= 1'b1;
              ram_addr <= row_base + {4'd0, col};
              ram_data <= {in_attr, 1'b0, in_char[6:0]};
              attr     <= in_attr;
              state    <= ST_WRITE;
              if (col == LAST_COL) begin
                col      <= 8'd0;
                row      <= row_nx;
                row_base <= base_nx;
                wrap     <= 1'b1;
              end else begin
                col  <= col + 8'd1;
                wrap <= 1'b0;
              end
            end else begin
              case (in_char)
                8'h0A: begin
                  col      <= 8'd0;
                  row      <= row_nx;
                  row_base <= base_nx;
                  attr     <= in_attr;
                  ram_ce   <= 1'b1;
                  ram_addr <= base_nx;
                  ram_data <= {in_attr, 8'h20};
                  clr_cnt  <= 13'd1;
                  state    <= ST_CLEAR_ROW;
                end
                8'h0D: col <= 8'd0;
                8'h08: if (col != 8'd0) col <= col - 8'd1;
                8'h0C: begin
                  col      <= 8'd0;
                  row      <= 8'd0;
                  row_base <= 12'd0;
                  attr     <= in_attr;
                  ram_ce   <= 1'b1;
                  ram_addr <= 12'd0;
                  ram_data <= {in_attr, 8'h20};
                  clr_cnt  <= 13'd1;
                  state    <= ST_CLEAR_ALL;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_console_writer.sv
// Directed bench for vram_console_writer with default geometry (50x15).
module tb_vram_console_writer;

  logic        clk_sys;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_char;
  logic [7:0]  in_attr;
  logic        in_ready;
  logic        ram_ce;
  logic [11:0] ram_addr;
  logic [15:0] ram_data;
  logic [7:0]  cur_col;
  logic [7:0]  cur_row;

  int checks = 0;
  int errors = 0;

  vram_console_writer dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .in_valid (in_valid),
    .in_char  (in_char),
    .in_attr  (in_attr),
    .in_ready (in_ready),
    .ram_ce   (ram_ce),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .cur_col  (cur_col),
    .cur_row  (cur_row)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, return at the following falling edge.
  task automatic tick();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  // Offer one byte for exactly one rising edge (called at a falling edge).
  task automatic send(input logic [7:0] c, input logic [7:0] a);
    in_valid = 1'b1;
    in_char  = c;
    in_attr  = a;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("wait_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    in_attr  = 8'h00;
    #3;
    chk("rst_ce",    {31'd0, ram_ce},   32'd0);
    chk("rst_addr",  {20'd0, ram_addr}, 32'd0);
    chk("rst_data",  {16'd0, ram_data}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_col",   {24'd0, cur_col},  32'd0);
    chk("rst_row",   {24'd0, cur_row},  32'd0);
    repeat (3) @(negedge clk_sys);
    reset = 1'b1;

    // Power-on clear: 750 writes of 0x0F20.
    for (int k = 0; k < 750; k++) begin
      tick();
      chk("clrall_ce",    {31'd0, ram_ce},   32'd1);
      chk("clrall_addr",  {20'd0, ram_addr}, 32'(k));
      chk("clrall_data",  {16'd0, ram_data}, 32'h0F20);
      chk("clrall_ready", {31'd0, in_ready}, 32'd0);
    end
    tick();
    chk("clrall_done_ready", {31'd0, in_ready}, 32'd1);
    chk("clrall_done_ce",    {31'd0, ram_ce},   32'd0);

    // Single printable char.
    send(8'h41, 8'h1E);
    chk("A_ce",    {31'd0, ram_ce},   32'd1);
    chk("A_addr",  {20'd0, ram_addr}, 32'd0);
    chk("A_data",  {16'd0, ram_data}, 32'h1E41);
    chk("A_col",   {24'd0, cur_col},  32'd1);
    chk("A_row",   {24'd0, cur_row},  32'd0);
    chk("A_busy",  {31'd0, in_ready}, 32'd0);
    tick();
    chk("A_ready", {31'd0, in_ready}, 32'd1);
    chk("A_ce_off", {31'd0, ram_ce},  32'd0);
    chk("A_hold_addr", {20'd0, ram_addr}, 32'd0);
    chk("A_hold_data", {16'd0, ram_data}, 32'h1E41);

    // CR back to column 0, back-to-back capable.
    send(8'h0D, 8'h00);
    chk("cr_col",   {24'd0, cur_col},  32'd0);
    chk("cr_ce",    {31'd0, ram_ce},   32'd0);
    chk("cr_ready", {31'd0, in_ready}, 32'd1);

    // Full line of 'x' then automatic clear of row 1.
    for (int i = 0; i < 50; i++) begin
      send(8'h78, 8'h07);
      chk("x_ce",   {31'd0, ram_ce},   32'd1);
      chk("x_addr", {20'd0, ram_addr}, 32'(i));
      chk("x_data", {16'd0, ram_data}, 32'h0778);
      if (i < 49) begin
        tick();
        chk("x_ready", {31'd0, in_ready}, 32'd1);
      end
    end
    for (int j = 0; j < 50; j++) begin
      tick();
      chk("wrap_ce",    {31'd0, ram_ce},   32'd1);
      chk("wrap_addr",  {20'd0, ram_addr}, 32'(50 + j));
      chk("wrap_data",  {16'd0, ram_data}, 32'h0720);
      chk("wrap_ready", {31'd0, in_ready}, 32'd0);
    end
    tick();
    chk("wrap_done_ready", {31'd0, in_ready}, 32'd1);
    chk("wrap_col", {24'd0, cur_col}, 32'd0);
    chk("wrap_row", {24'd0, cur_row}, 32'd1);

    // Advance to row 14 with LFs.
    for (int r = 0; r < 13; r++) begin
      send(8'h0A, 8'h07);
      wait_ready();
    end
    chk("row14", {24'd0, cur_row}, 32'd14);

    // LF at the last row wraps to row 0 and blanks it.
    send(8'h0A, 8'h20);
    chk("lfw_ce",   {31'd0, ram_ce},   32'd1);
    chk("lfw_addr", {20'd0, ram_addr}, 32'd0);
    chk("lfw_data", {16'd0, ram_data}, 32'h2020);
    chk("lfw_row",  {24'd0, cur_row},  32'd0);
    chk("lfw_col",  {24'd0, cur_col},  32'd0);
    for (int j = 1; j < 50; j++) begin
      tick();
      chk("lfw_clr_ce",   {31'd0, ram_ce},   32'd1);
      chk("lfw_clr_addr", {20'd0, ram_addr}, 32'(j));
      chk("lfw_clr_data", {16'd0, ram_data}, 32'h2020);
    end
    tick();
    chk("lfw_ready", {31'd0, in_ready}, 32'd1);
    chk("lfw_ce_off", {31'd0, ram_ce},  32'd0);

    // Move to col 3, then backspace behaviour.
    send(8'h61, 8'h07); tick();
    send(8'h62, 8'h07); tick();
    send(8'h63, 8'h07); tick();
    chk("col3", {24'd0, cur_col}, 32'd3);
    send(8'h08, 8'h00);
    chk("bs_col",   {24'd0, cur_col},  32'd2);
    chk("bs_ce",    {31'd0, ram_ce},   32'd0);
    chk("bs_ready", {31'd0, in_ready}, 32'd1);
    send(8'h08, 8'h00);
    chk("bs2_col", {24'd0, cur_col}, 32'd1);
    send(8'h08, 8'h00);
    chk("bs3_col", {24'd0, cur_col}, 32'd0);
    send(8'h08, 8'h00);
    chk("bs4_col", {24'd0, cur_col}, 32'd0);
    chk("bs4_ce",  {31'd0, ram_ce},  32'd0);

    for (int i = 0; i < 7; i++) begin
      send(8'h71, 8'h07);
      tick();
    end
    chk("col7", {24'd0, cur_col}, 32'd7);
    send(8'h0D, 8'h00);
    chk("cr7_col", {24'd0, cur_col}, 32'd0);
    chk("cr7_row", {24'd0, cur_row}, 32'd0);

    // Ignored bytes on both sides of the printable range.
    send(8'h80, 8'h07);
    chk("ign80_ce",    {31'd0, ram_ce},   32'd0);
    chk("ign80_ready", {31'd0, in_ready}, 32'd1);
    chk("ign80_col",   {24'd0, cur_col},  32'd0);
    send(8'h1F, 8'h07);
    chk("ign1f_ce",  {31'd0, ram_ce},  32'd0);
    chk("ign1f_col", {24'd0, cur_col}, 32'd0);
    send(8'h7F, 8'h07);
    chk("ign7f_ce",  {31'd0, ram_ce},  32'd0);

    // Printable range edges.
    send(8'h7E, 8'h34);
    chk("tilde_addr", {20'd0, ram_addr}, 32'd0);
    chk("tilde_data", {16'd0, ram_data}, 32'h347E);
    tick();
    send(8'h20, 8'h34);
    chk("space_addr", {20'd0, ram_addr}, 32'd1);
    chk("space_data", {16'd0, ram_data}, 32'h3420);
    tick();

    // Form feed, then reset in the middle of the clear.
    send(8'h0C, 8'h55);
    chk("ff_ce",   {31'd0, ram_ce},   32'd1);
    chk("ff_addr", {20'd0, ram_addr}, 32'd0);
    chk("ff_data", {16'd0, ram_data}, 32'h5520);
    chk("ff_col",  {24'd0, cur_col},  32'd0);
    chk("ff_row",  {24'd0, cur_row},  32'd0);
    repeat (300) tick();
    chk("ff300_ce",   {31'd0, ram_ce},   32'd1);
    chk("ff300_addr", {20'd0, ram_addr}, 32'd300);
    chk("ff300_data", {16'd0, ram_data}, 32'h5520);
    reset = 1'b0;
    #1;
    chk("mid_rst_ce",    {31'd0, ram_ce},   32'd0);
    chk("mid_rst_addr",  {20'd0, ram_addr}, 32'd0);
    chk("mid_rst_data",  {16'd0, ram_data}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk_sys);
    reset = 1'b1;
    tick();
    chk("restart_ce",   {31'd0, ram_ce},   32'd1);
    chk("restart_addr", {20'd0, ram_addr}, 32'd0);
    chk("restart_data", {16'd0, ram_data}, 32'h0F20);
    tick();
    chk("restart_addr1", {20'd0, ram_addr}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_console_writer.md
# vram_console_writer

Character-stream writer for the text-mode VRAM write port that feeds the LCD display pipeline. It accepts ASCII bytes with a colour attribute over a valid/ready handshake and maintains a cursor. It turns printable characters and control codes into single-cycle VRAM word writes. Line advances wrap to the top and blank the new line, so no VRAM read-back is needed. Sits between the CPU/UART console path and the VRAM write port (`ram_clk` = `clk_sys` at top level).

## Interface
- `COLS`, default 50: characters per line (direction 0 layout).
- `ROWS`, default 15: lines per screen; `COLS*ROWS` ≤ 4096.
- `RESET_ATTR`, default 8'h0F: attribute used for the power-on clear.
- `clk_sys`  in  1: single clock. All logic is on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: a byte is offered.
- `in_char`  in  8: ASCII byte.
- `in_attr`  in  8: {bg[3:0], fg[3:0]}, sampled together with `in_char`.
- `in_ready`  out  1: the block can accept a byte.
- `ram_ce`  out  1: one-cycle write strobe to the VRAM port A.
- `ram_addr`  out  12: cell address, row*COLS + col.
- `ram_data`  out  16: {attr[7:0], 1'b0, char[6:0]}.
- `cur_col`  out  8: cursor column.
- `cur_row`  out  8: cursor row.

## Operation
- A byte is accepted on a rising edge where `in_valid` && `in_ready`. `in_ready` is 1 only in IDLE.
- States:
  - CLEAR_ALL: blanks every cell, one write per cycle.
  - IDLE.
  - WRITE: a single write cycle.
  - CLEAR_ROW: blanks COLS cells, one write per cycle.
- Blank cell data is {attr, 8'h20}. The attr is the one latched from the byte that triggered the clear, or RESET_ATTR after reset.
- Byte decode in IDLE:
  - 0x20–0x7E (printable): go to WRITE and write to cell (row, col). Then:
    - If col < COLS-1: col+1, return to IDLE.
    - If col = COLS-1: col ← 0, row ← (row+1) mod ROWS, go to CLEAR_ROW on the new row.
  - 0x0A LF: col ← 0, row ← (row+1) mod ROWS, go to CLEAR_ROW. No character write.
  - 0x0D CR: col ← 0. Stays in IDLE, no write.
  - 0x08 BS: col ← col-1 if col > 0. No erase, no write.
  - 0x0C FF: go to CLEAR_ALL, cursor ← (0,0).
  - Any other value (0x00–0x1F not listed, 0x7F–0xFF): consumed and discarded, no write.
- Row wrap from ROWS-1 goes to row 0. There is no scrolling; the newly entered row is always blanked.
- Address generation:
  - Keep `row_base` = row*COLS incrementally. On advance add COLS; on wrap set to 0. No multiplier.
  - The clear counter counts 0..COLS-1 (CLEAR_ROW) or 0..COLS*ROWS-1 (CLEAR_ALL), at least 12 bits.
  - `ram_addr` upper bits are zero-extended.

## Timing
- Reset values:
  - `ram_ce`=0, `ram_addr`=0, `ram_data`=0.
  - `in_ready`=0, `cur_col`=0, `cur_row`=0.
  - State = CLEAR_ALL with attr = RESET_ATTR.
- After reset release, CLEAR_ALL writes addresses 0..COLS*ROWS-1 on consecutive cycles 1..COLS*ROWS. `in_ready` rises in cycle COLS*ROWS+1.
- Printable byte accepted at edge N:
  - `ram_ce`=1 with address and data in the cycle after edge N. The `ram_*` outputs are registered.
  - The cursor updates at the same edge.
  - No wrap: `in_ready` is high again in cycle N+2, so the sustained rate is one char per 2 cycles.
  - Wrap: the row clear follows with writes in cycles N+2..N+1+COLS, and `in_ready` rises in cycle N+2+COLS.
- LF accepted at edge N: clear writes in cycles N+1..N+COLS, `in_ready` high in cycle N+COLS+1.
- CR, BS and ignored bytes: `in_ready` stays 1, so back-to-back acceptance is allowed. The cursor updates at the accept edge.
- FF accepted at edge N: COLS*ROWS writes in cycles N+1..N+COLS*ROWS.
- `ram_ce` is deasserted in every cycle with no write. `ram_addr` and `ram_data` hold their last values when `ram_ce`=0.
- Reset asserted mid-operation: all outputs go immediately to their reset values. After release, CLEAR_ALL restarts from address 0.

## Test plan
- Release reset with defaults -> 750 consecutive `ram_ce` pulses, addresses 0..749, data 16'h0F20; `in_ready`=1 in cycle 751.
- 'A' (0x41) with attr 0x1E at cursor (0,0) -> one write, addr 0, data 16'h1E41; cursor becomes (col 1, row 0); `in_ready` high 2 cycles after accept.
- 50 × 'x' (0x78) with attr 0x07 from (0,0) -> writes at addresses 0..49 data 16'h0778, then 50 clears at addresses 50..99 data 16'h0720; cursor (0,1).
- Cursor at row 14, LF with attr 0x20 -> clears at addresses 0..49 data 16'h2020; cursor (0,0); no write at row 14.
- Cursor col 3: BS -> col 2, no `ram_ce`. BS ×3 -> col 0 and stays 0. CR from col 7 -> col 0. Byte 0x80 -> consumed, no write.
- Assert reset during an FF clear at address 300 -> `ram_ce`=0 and `ram_addr`=0 immediately; after release, writes restart at addr 0 with data 16'h0F20.
